// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: FSM encoding, data widths
// and the MEM/WB bundle carried into writeback.
package memory_access_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [1:0] ENC_IDLE = 2'b00;
  localparam logic [1:0] ENC_BUSY = 2'b01;
  localparam logic [1:0] ENC_ERR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_BUSY = ENC_BUSY,
    ST_ERR  = ENC_ERR
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] mem_out;
    logic [DATA_W-1:0] data;
    logic              cond;
    logic              pc_to_reg;
    logic              mem_to_reg;
    logic              set;
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
  } wb_bundle_t;

endpackage

// File: rtl/memory_access_mem_wb_reg.sv
// MEM/WB pipeline register. On a non-load edge only the qualifiers drop so a
// bubble never writes the register file; the payload simply holds.
module mem_wb_reg
  import memory_access_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  wb_bundle_t d,
  output wb_bundle_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q.valid     <= 1'b0;
      q.reg_write <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores to the memory port, stalls
// the front of the pipe on wait states and traps misaligned accesses.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepting EX/MEM; zero-wait hits and non-memory ops pass through
//   BUSY  | request outstanding, replayed from registered copies, stalling
//   ERR   | misaligned access seen; pipe frozen until reset
module memory_access
  import memory_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] PCInc,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Cond,
  input  logic              PCtoReg,
  input  logic              MemtoReg,
  input  logic              Set,
  input  logic              RegWrite,
  input  logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              stall_out,
  output logic              err,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_PCInc,
  output logic [DATA_W-1:0] wb_MemOut,
  output logic [DATA_W-1:0] wb_Data,
  output logic              wb_Cond,
  output logic              wb_PCtoReg,
  output logic              wb_MemtoReg,
  output logic              wb_Set,
  output logic              wb_RegWrite,
  output logic [REG_W-1:0]  wb_WriteReg
);

  state_t            state_q, state_nxt;
  logic              mem_op, misaligned;
  logic              rd_c, wr_c, stall_c, advance, capture, load_sel;
  logic [DATA_W-1:0] addr_c, wdata_c;
  logic              req_rd_q, req_wr_q;
  logic [DATA_W-1:0] req_addr_q, req_wdata_q;
  wb_bundle_t        wb_d, wb_q;

  assign mem_op     = in_valid & (MemRead | MemWrite);
  assign misaligned = mem_op & ALUOut[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    addr_c    = ALUOut;
    wdata_c   = WriteData;
    stall_c   = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    load_sel  = MemRead & ~MemWrite;
    case (state_q)
      ST_IDLE: begin
        if (misaligned) begin
          stall_c   = 1'b1;
          state_nxt = ST_ERR;
        end else if (mem_op) begin
          // A simultaneous read+write is treated as a plain store.
          rd_c = MemRead & ~MemWrite;
          wr_c = MemWrite;
          if (mem_done) begin
            advance = 1'b1;
          end else begin
            stall_c   = 1'b1;
            capture   = 1'b1;
            state_nxt = ST_BUSY;
          end
        end else if (in_valid) begin
          advance = 1'b1;
        end
      end
      ST_BUSY: begin
        rd_c     = req_rd_q;
        wr_c     = req_wr_q;
        addr_c   = req_addr_q;
        wdata_c  = req_wdata_q;
        load_sel = req_rd_q;
        if (mem_done) begin
          advance   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_ERR: begin
        stall_c = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (capture) begin
      req_rd_q    <= rd_c;
      req_wr_q    <= wr_c;
      req_addr_q  <= ALUOut;
      req_wdata_q <= WriteData;
    end
  end

  // Request and stall are masked by reset so they drop the instant rst falls.
  assign mem_rd    = rd_c & rst;
  assign mem_wr    = wr_c & rst;
  assign stall_out = stall_c & rst;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign err       = (state_q == ST_ERR);

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = 1'b1;
    wb_d.pc_inc     = PCInc;
    wb_d.mem_out    = load_sel ? mem_rdata : '0;
    wb_d.data       = ALUOut;
    wb_d.cond       = Cond;
    wb_d.pc_to_reg  = PCtoReg;
    wb_d.mem_to_reg = MemtoReg;
    wb_d.set        = Set;
    wb_d.reg_write  = RegWrite;
    wb_d.write_reg  = WriteReg;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk  (clk),
    .rst  (rst),
    .load (advance),
    .d    (wb_d),
    .q    (wb_q)
  );

  assign wb_valid    = wb_q.valid;
  assign wb_PCInc    = wb_q.pc_inc;
  assign wb_MemOut   = wb_q.mem_out;
  assign wb_Data     = wb_q.data;
  assign wb_Cond     = wb_q.cond;
  assign wb_PCtoReg  = wb_q.pc_to_reg;
  assign wb_MemtoReg = wb_q.mem_to_reg;
  assign wb_Set      = wb_q.set;
  assign wb_RegWrite = wb_q.reg_write;
  assign wb_WriteReg = wb_q.write_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, zero-wait load, waited store,
// reset during a wait, and the sticky misalignment trap.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] ALUOut, WriteData, PCInc;
  logic        MemRead, MemWrite, Cond, PCtoReg, MemtoReg, Set, RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, stall_out, err;
  logic        wb_valid, wb_Cond, wb_PCtoReg, wb_MemtoReg, wb_Set, wb_RegWrite;
  logic [15:0] wb_PCInc, wb_MemOut, wb_Data;
  logic [2:0]  wb_WriteReg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .ALUOut(ALUOut), .WriteData(WriteData), .PCInc(PCInc),
    .MemRead(MemRead), .MemWrite(MemWrite), .Cond(Cond), .PCtoReg(PCtoReg),
    .MemtoReg(MemtoReg), .Set(Set), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_out(stall_out), .err(err),
    .wb_valid(wb_valid), .wb_PCInc(wb_PCInc), .wb_MemOut(wb_MemOut),
    .wb_Data(wb_Data), .wb_Cond(wb_Cond), .wb_PCtoReg(wb_PCtoReg),
    .wb_MemtoReg(wb_MemtoReg), .wb_Set(wb_Set), .wb_RegWrite(wb_RegWrite),
    .wb_WriteReg(wb_WriteReg)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; MemRead = 0; MemWrite = 0; Cond = 0; PCtoReg = 0;
    MemtoReg = 0; Set = 0; RegWrite = 0; WriteReg = 3'd0;
  endtask

  initial begin
    idle_inputs();
    ALUOut = 16'h0000; WriteData = 16'h0000; PCInc = 16'h0000;
    mem_rdata = 16'h0000; mem_done = 0;

    // Reset with a load presented: request and stall must stay low.
    rst = 0;
    in_valid = 1; MemRead = 1; ALUOut = 16'h0040;
    #2;
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_stall", stall_out, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk16("rst_wb_data", wb_Data, 16'h0000);
    idle_inputs();
    next_cycle();
    rst = 1;

    // ADD pass-through
    in_valid = 1; RegWrite = 1; ALUOut = 16'h1234; PCInc = 16'h0002; WriteReg = 3'd3;
    #4;
    chk1("add_stall", stall_out, 1'b0);
    chk1("add_mem_rd", mem_rd, 1'b0);
    next_cycle();
    chk1("add_wb_valid", wb_valid, 1'b1);
    chk16("add_wb_data", wb_Data, 16'h1234);
    chk16("add_wb_pcinc", wb_PCInc, 16'h0002);
    chk16("add_wb_wreg", {13'd0, wb_WriteReg}, 16'h0003);
    chk1("add_wb_regwrite", wb_RegWrite, 1'b1);
    chk16("add_wb_memout", wb_MemOut, 16'h0000);
    idle_inputs();
    #4;
    chk1("bubble_stall", stall_out, 1'b0);
    next_cycle();
    chk1("bubble_wb_valid", wb_valid, 1'b0);
    chk1("bubble_wb_regwrite", wb_RegWrite, 1'b0);
    chk16("bubble_wb_data_hold", wb_Data, 16'h1234);

    // Zero-wait load hit
    in_valid = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; ALUOut = 16'h0040;
    mem_done = 1; mem_rdata = 16'hBEEF;
    #4;
    chk1("ld_mem_rd", mem_rd, 1'b1);
    chk1("ld_mem_wr", mem_wr, 1'b0);
    chk16("ld_mem_addr", mem_addr, 16'h0040);
    chk1("ld_stall", stall_out, 1'b0);
    next_cycle();
    chk1("ld_wb_valid", wb_valid, 1'b1);
    chk16("ld_wb_memout", wb_MemOut, 16'hBEEF);
    chk16("ld_wb_data", wb_Data, 16'h0040);
    chk1("ld_wb_memtoreg", wb_MemtoReg, 1'b1);
    idle_inputs(); mem_done = 0;

    // Store with 3 wait cycles; MemRead also set, so it must act as a write only.
    // Inputs are disturbed mid-wait to prove the request replays from its copies.
    in_valid = 1; MemWrite = 1; MemRead = 1; ALUOut = 16'h0100; WriteData = 16'h00AA;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin ALUOut = 16'hFFFE; WriteData = 16'h5555; end
      if (c == 4) begin ALUOut = 16'h0100; WriteData = 16'h00AA; mem_done = 1; end
      #4;
      chk1($sformatf("st_stall_c%0d", c), stall_out, (c < 4));
      chk1($sformatf("st_mem_wr_c%0d", c), mem_wr, 1'b1);
      chk1($sformatf("st_mem_rd_c%0d", c), mem_rd, 1'b0);
      chk16($sformatf("st_addr_c%0d", c), mem_addr, 16'h0100);
      chk16($sformatf("st_wdata_c%0d", c), mem_wdata, 16'h00AA);
      next_cycle();
      chk1($sformatf("st_wb_valid_c%0d", c), wb_valid, (c == 4));
    end
    chk16("st_wb_memout", wb_MemOut, 16'h0000);
    chk16("st_wb_data", wb_Data, 16'h0100);
    idle_inputs(); mem_done = 0;
    #4;
    next_cycle();
    chk1("st_wb_valid_once", wb_valid, 1'b0);

    // Stray mem_done with nothing outstanding
    mem_done = 1; mem_rdata = 16'h1111;
    #4;
    chk1("stray_stall", stall_out, 1'b0);
    next_cycle();
    chk1("stray_wb_valid", wb_valid, 1'b0);
    chk16("stray_wb_memout", wb_MemOut, 16'h0000);
    mem_done = 0;

    // Reset while BUSY, then a late completion
    in_valid = 1; MemRead = 1; RegWrite = 1; ALUOut = 16'h0200;
    #4;
    chk1("rb_issue_stall", stall_out, 1'b1);
    next_cycle();
    #2;
    chk1("rb_busy_mem_rd", mem_rd, 1'b1);
    chk16("rb_busy_addr", mem_addr, 16'h0200);
    rst = 0;
    #1;
    chk1("rb_rst_mem_rd", mem_rd, 1'b0);
    chk1("rb_rst_stall", stall_out, 1'b0);
    chk16("rb_rst_wb_data", wb_Data, 16'h0000);
    chk16("rb_rst_wb_pcinc", wb_PCInc, 16'h0000);
    idle_inputs();
    next_cycle();
    rst = 1;
    mem_done = 1; mem_rdata = 16'h2222;
    #4;
    chk1("rb_late_stall", stall_out, 1'b0);
    chk1("rb_late_mem_rd", mem_rd, 1'b0);
    next_cycle();
    chk1("rb_late_wb_valid", wb_valid, 1'b0);
    chk16("rb_late_wb_memout", wb_MemOut, 16'h0000);
    mem_done = 0;

    // Misaligned load traps
    in_valid = 1; MemRead = 1; RegWrite = 1; ALUOut = 16'h0041;
    #4;
    chk1("mis_mem_rd", mem_rd, 1'b0);
    chk1("mis_err_same", err, 1'b0);
    next_cycle();
    chk1("mis_err", err, 1'b1);
    chk1("mis_wb_valid", wb_valid, 1'b0);
    idle_inputs();
    in_valid = 1; RegWrite = 1; ALUOut = 16'h0010; mem_done = 1;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk1($sformatf("err_stall_c%0d", c), stall_out, 1'b1);
      chk1($sformatf("err_mem_rd_c%0d", c), mem_rd, 1'b0);
      next_cycle();
      chk1($sformatf("err_sticky_c%0d", c), err, 1'b1);
      chk1($sformatf("err_wb_valid_c%0d", c), wb_valid, 1'b0);
    end
    rst = 0;
    #1;
    chk1("err_cleared", err, 1'b0);
    chk1("err_rst_stall", stall_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, with ports named as the codebase does: clk, rst.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 ALUOut, WriteData, PCInc  in  16 each  address/ALU result, store data, PC+2.
REQ-006 MemRead, MemWrite, Cond, PCtoReg, MemtoReg, Set, RegWrite  in  1 each  decoded controls.
REQ-007 WriteReg  in  3  destination register.
REQ-008 mem_addr, mem_wdata  out  16 each  address and store data to the memory/cache.
REQ-009 mem_rd, mem_wr  out  1 each  read/write request.
REQ-010 mem_rdata  in  16  load data; mem_done  in  1  one-cycle completion pulse.
REQ-011 stall_out  out  1  freezes IF/ID/EX stages while high.
REQ-012 err  out  1  sticky misaligned-access error.
REQ-013 wb_valid, wb_PCInc, wb_MemOut, wb_Data, wb_Cond, wb_PCtoReg, wb_MemtoReg, wb_Set, wb_RegWrite, wb_WriteReg  out  MEM/WB register feeding writeback, with the same widths as their sources.

Function
REQ-014 FSM states: IDLE, BUSY, ERR; encoding 2 bits.
REQ-015 mem_op = in_valid & (MemRead | MemWrite); misaligned = mem_op & ALUOut[0].
REQ-016 IDLE, mem_op and aligned: mem_rd = MemRead and mem_wr = MemWrite, driven combinationally; mem_addr = ALUOut; mem_wdata = WriteData.
REQ-017 IDLE with mem_done high in the same cycle as the request (zero-wait hit): stage advances, state stays IDLE, stall_out = 0.
REQ-018 IDLE, request issued, mem_done low: next state BUSY; stall_out = 1 combinationally in that cycle.
REQ-019 BUSY: request signals and address/data held stable from registered copies; stall_out = 1 until the cycle mem_done is high; on mem_done, stage advances and next state is IDLE.
REQ-020 MemRead and MemWrite both high: treat as write only.
REQ-021 misaligned in IDLE: no request issued; next state ERR; err = 1 from the next cycle; that instruction retires as a bubble.
REQ-022 ERR: stall_out = 1, no requests, wb_valid = 0, err = 1; exit only via reset.
REQ-023 advance = in_valid & ~mem_op in IDLE, or mem_done in IDLE/BUSY while a request is outstanding.
REQ-024 On advance, the MEM/WB register loads all controls and PCInc; wb_Data = ALUOut; wb_MemOut = mem_rdata for loads and 16'h0000 otherwise; wb_valid = 1.
REQ-025 On a non-advance edge: wb_valid = 0, wb_RegWrite = 0; other wb_* hold their values.
REQ-026 mem_done while no request is outstanding SHALL be ignored.
REQ-027 Latency: non-memory op 1 cycle; memory op 1 cycle plus wait cycles until mem_done.

Reset
REQ-028 rst low: state IDLE, err = 0, all wb_* = 0 asynchronously; mem_rd, mem_wr and stall_out = 0 immediately.
REQ-029 Reset asserted in BUSY abandons the outstanding request; a late mem_done after reset release is ignored per REQ-026.

Structure
REQ-030 Shared package holds the state encoding constants and the data-width constant (16).
REQ-031 One sub-module, mem_wb_reg: async-reset, load-enabled pipeline register for the wb_* bundle; the FSM and request logic stay in memory_access.

Verification
REQ-032 ADD, in_valid = 1, RegWrite = 1, ALUOut = 16'h1234 -> next cycle wb_valid = 1, wb_Data = 16'h1234, stall_out never high.
REQ-033 Load ALUOut = 16'h0040, mem_done high same cycle with mem_rdata = 16'hBEEF -> next cycle wb_MemOut = 16'hBEEF, no stall.
REQ-034 Store ALUOut = 16'h0100, WriteData = 16'h00AA, mem_done after 3 wait cycles -> stall_out high for 4 cycles, mem_wr/mem_addr/mem_wdata stable throughout, wb_valid = 1 exactly once.
REQ-035 Load ALUOut = 16'h0041 -> no mem_rd, err = 1 next cycle and stays high, stall_out = 1 until reset.
REQ-036 rst low during BUSY, then mem_done pulse after release -> state IDLE, all wb_* = 0, wb_valid stays 0.
